// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_pkg
// Brief    : Shared types and constants for the fetch / PC-generation slice.
//            Holds the fetch FSM state type, branch funct3 encodings (the
//            comparator uses the same mode encoding) and the sequential
//            PC increment.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DELIVER = 2'd1,
        KILL    = 2'd2
    } state_t;

    // Conditional-branch funct3 encodings, shared with the comparator mode
    localparam logic [2:0] c_BEQ  = 3'b000;
    localparam logic [2:0] c_BNE  = 3'b001;
    localparam logic [2:0] c_BLT  = 3'b100;
    localparam logic [2:0] c_BGE  = 3'b101;
    localparam logic [2:0] c_BLTU = 3'b110;
    localparam logic [2:0] c_BGEU = 3'b111;

    // Sequential fetch step; stays 4 even when 2-byte targets are legal
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

`default_nettype wire

// File: rtl/pc_gen_if.sv
//------------------------------------------------------------------------------
// Module   : pc_gen_if
// Brief    : Fetch-side bus bundle: instruction-memory req/ack channel and the
//            valid/ready channel that hands fetched PCs to decode.
//            master = PC generator, slave = memory + decode side.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pc_gen_if;

    // Instruction-memory request channel
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;

    // Delivery channel to decode
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        output if_valid,
        output if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        input  if_valid,
        input  if_pc,
        output if_ready
    );

endinterface

`default_nettype wire

// File: rtl/branch_target.sv
//------------------------------------------------------------------------------
// Module   : branch_target
// Brief    : Combinational taken / target / misalignment resolution for
//            JAL, JALR and conditional branches.
//            Build option CMP_COMPRESSED_EN: 2-byte targets are legal and the
//            misaligned flag is never raised.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_target
    import cpu_pkg::*;
(
    input  wire logic        i_is_jal,
    input  wire logic        i_is_jalr,
    input  wire logic        i_cmp_q,
    input  wire logic [31:0] i_br_pc,
    input  wire logic [31:0] i_br_imm,
    input  wire logic [31:0] i_rs1,
    output logic             o_taken,
    output logic [31:0]      o_target,
    output logic             o_misaligned
);

    logic [31:0] w_pc_rel;
    logic [31:0] w_reg_rel;

    // Both candidate sums wrap modulo 2^32; overflow is not an error
    assign w_pc_rel  = i_br_pc + i_br_imm;
    assign w_reg_rel = (i_rs1 + i_br_imm) & ~32'd1;

    // Select the target and decide whether the transfer is taken
    always_comb begin
        o_taken  = i_cmp_q;
        o_target = w_pc_rel;
        if (i_is_jalr) begin
            o_taken  = 1'b1;
            o_target = w_reg_rel;
        end else if (i_is_jal) begin
            o_taken  = 1'b1;
            o_target = w_pc_rel;
        end
    end

`ifdef CMP_COMPRESSED_EN
    assign o_misaligned = 1'b0;
`else
    // Only meaningful when qualified with o_taken by the caller
    assign o_misaligned = o_target[1];
`endif

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
//------------------------------------------------------------------------------
// Module   : pc_gen
// Brief    : Program counter and fetch-redirect stage. Issues fetches over a
//            req/ack channel, hands fetched PCs to decode over valid/ready,
//            redirects on taken control transfers, squashes the in-flight
//            fetch and flags misaligned targets.
//            Build option CMP_COMPRESSED_EN (in branch_target): 2-byte
//            target alignment, no misaligned trap.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_gen
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_br_valid,
    input  wire logic        i_br_is_jal,
    input  wire logic        i_br_is_jalr,
    input  wire logic        i_cmp_q,
    input  wire logic [31:0] i_br_pc,
    input  wire logic [31:0] i_br_imm,
    input  wire logic [31:0] i_rs1,
    pc_gen_if.master         bus,
    output logic             o_flush,
    output logic             o_trap_misaligned,
    output logic [31:0]      o_trap_pc
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_live;        // low for the first cycle out of reset: no request yet
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_kill_addr;   // address of the abandoned fetch being drained
    logic [31:0] w_kill_nxt;
    logic        r_flush;
    logic        r_trap;
    logic [31:0] r_trap_pc;

    logic        w_taken;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_squash;
    logic        w_redirect;
    logic        w_trap;
    logic [31:0] w_squash_pc;

    branch_target u_branch_target (
        .i_is_jal     (i_br_is_jal),
        .i_is_jalr    (i_br_is_jalr),
        .i_cmp_q      (i_cmp_q),
        .i_br_pc      (i_br_pc),
        .i_br_imm     (i_br_imm),
        .i_rs1        (i_rs1),
        .o_taken      (w_taken),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    // A trap squashes like a redirect but keeps the current pc
    assign w_squash    = i_br_valid & w_taken;
    assign w_trap      = w_squash & w_misaligned;
    assign w_redirect  = w_squash & ~w_misaligned;
    assign w_squash_pc = w_redirect ? w_target : r_pc;

    // State, pc and drain-address registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FETCH;
            r_live      <= 1'b0;
            r_pc        <= RESET_PC;
            r_kill_addr <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_live      <= 1'b1;
            r_pc        <= w_pc_nxt;
            r_kill_addr <= w_kill_nxt;
        end
    end

    // Next-state / next-pc decision; a squash always beats ack or ready
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill_addr;
        if (!r_live) begin
            w_pc_nxt = w_squash_pc;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_squash) begin
                        w_pc_nxt = w_squash_pc;
                        if (!bus.imem_ack) begin
                            w_state_nxt = KILL;
                            w_kill_nxt  = r_pc;
                        end
                    end else if (bus.imem_ack) begin
                        w_state_nxt = DELIVER;
                    end
                end
                DELIVER: begin
                    if (w_squash) begin
                        w_pc_nxt    = w_squash_pc;
                        w_state_nxt = FETCH;
                    end else if (bus.if_ready) begin
                        w_pc_nxt    = r_pc + PC_STEP;
                        w_state_nxt = FETCH;
                    end
                end
                KILL: begin
                    if (w_squash) begin
                        w_pc_nxt = w_squash_pc;
                    end
                    if (bus.imem_ack) begin
                        w_state_nxt = FETCH;
                    end
                end
                default: begin
                    w_state_nxt = FETCH;
                end
            endcase
        end
    end

    // One-cycle flush / trap pulses and the sticky trap PC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush   <= 1'b0;
            r_trap    <= 1'b0;
            r_trap_pc <= 32'd0;
        end else begin
            r_flush <= w_squash;
            r_trap  <= w_trap;
            if (w_trap) begin
                r_trap_pc <= i_br_pc;
            end
        end
    end

    assign bus.imem_req  = r_live & (r_state != DELIVER);
    assign bus.imem_addr = (r_state == KILL) ? r_kill_addr : r_pc;
    assign bus.if_valid  = r_live & (r_state == DELIVER);
    assign bus.if_pc     = r_pc;

    assign o_flush           = r_flush;
    assign o_trap_misaligned = r_trap;
    assign o_trap_pc         = r_trap_pc;

endmodule

`default_nettype wire

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter and fetch-redirect stage; consumes the branch-compare result `q` from the execute-stage comparator.
- Holds the architectural fetch PC and issues requests to instruction memory over a req/ack handshake.
- Delivers fetched PCs to decode over a valid/ready handshake.
- Resolves branch/JAL/JALR targets, redirects fetch, squashes the in-flight fetch and raises a misaligned-target trap.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- br_valid  in  1  execute stage presents a resolved control-transfer instruction this cycle.
- br_is_jal  in  1  instruction is JAL.
- br_is_jalr  in  1  instruction is JALR.
- cmp_q  in  1  comparator result for conditional branches; ignored for JAL/JALR.
- br_pc  in  32  PC of the control-transfer instruction.
- br_imm  in  32  sign-extended immediate.
- rs1  in  32  rs1 value, JALR base.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  memory accepts/completes the request.
- if_valid  out  1  fetched PC available to decode.
- if_pc  out  32  PC of delivered fetch.
- if_ready  in  1  decode accepts.
- flush  out  1  one-cycle pulse: squash younger pipeline ops.
- trap_misaligned  out  1  one-cycle pulse: taken target misaligned.
- trap_pc  out  32  br_pc of the trapping instruction, held until the next trap.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, if_valid=0, flush=0, trap_misaligned=0, trap_pc=0.
  - First request issues in the first cycle after rst deasserts.
- Handshakes:
  - imem_req is level; imem_addr stays stable while imem_req=1 until imem_ack.
  - if_valid holds with stable if_pc until if_ready.
- Taken/target:
  - JAL: taken=1, target=br_pc+br_imm.
  - JALR: taken=1, target=(rs1+br_imm)&~1.
  - Branch (neither flag set): taken=cmp_q, target=br_pc+br_imm.
  - All sums are modulo 2^32; wrap-around is not an error.
- Misalignment: target[1]=1 with taken=1 → no redirect; trap_misaligned=1 for one cycle; trap_pc=br_pc; flush=1.
- Redirect: br_valid & taken & aligned → pc<=target and flush=1 for one cycle.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
    - ack & no redirect → DELIVER.
    - redirect & no ack → KILL.
    - redirect & ack → discard the fetch, stay FETCH with the new pc.
  - DELIVER: if_valid=1, if_pc=pc, imem_req=0.
    - if_ready & no redirect → pc<=pc+4, FETCH.
    - redirect → if_valid drops next cycle, FETCH with the new pc (redirect beats if_ready).
  - KILL: imem_req=1, imem_addr=old in-flight address.
    - ack → discard, FETCH.
    - further redirect → pc updated, stay KILL.
- Trap takes priority over redirect.
- Trap squashes like a redirect, but pc continues sequentially; trap-vector redirect is an external concern.
- Reset mid-transaction: outstanding request is abandoned; memory must tolerate req dropping.

Optional Feature:
- CMP_COMPRESSED_EN defined: 2-byte alignment; target[1] is legal, trap_misaligned never asserts, sequential step remains +4.
- Undefined: 4-byte alignment check as above.

Decomposition:
- cpu_pkg holds:
  - state enum {FETCH, DELIVER, KILL};
  - funct3 constants BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111, matching comparator mode encoding;
  - PC_STEP=4.
- Sub-module branch_target: combinational taken/target/misaligned computation.

Test Plan:
- Reset release, RESET_PC=0x100, ack every cycle, if_ready=1 → imem_addr 0x100, 0x104, 0x108; if_pc follows one cycle behind each ack.
- BEQ br_pc=0x200, imm=0x40, cmp_q=1 during DELIVER → flush pulse, next imem_addr=0x240; cmp_q=0 → no flush, sequential flow.
- JALR rs1=0x1001, imm=0x2 → target 0x1002.
  - Without CMP_COMPRESSED_EN: trap_misaligned pulse, trap_pc=br_pc, no redirect.
  - With CMP_COMPRESSED_EN: redirect to 0x1002.
- JAL during FETCH with ack held low 3 cycles:
  - KILL holds old imem_addr until ack;
  - acked data is not delivered (if_valid stays 0);
  - next request is to the target.
- if_ready low 4 cycles → if_valid/if_pc stable, no new imem_req.
- rst asserted mid-DELIVER: outputs clear asynchronously, pc=RESET_PC.
- JAL br_pc=0xFFFF_FFF0, imm=0x20 → target wraps to 0x10.
